wb_buffer: RTL and testbench
============================

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16, words per cache block.
REQ-003 SHALL have parameter ADDR_SIZE, default 28, block-address width (tag plus index, offset stripped).
REQ-004 SHALL have parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port evict_valid  input  1  cache presents a dirty block to buffer.
REQ-008 SHALL have port evict_addr  input  ADDR_SIZE  block address of evicted block.
REQ-009 SHALL have port evict_block  input  WORD_SIZE*BLOCK_SIZE  evicted block data, word 0 in the MSBs.
REQ-010 SHALL have port evict_ready  output  1  buffer accepts a push this cycle.
REQ-011 SHALL have port snoop_addr  input  ADDR_SIZE  block address of a cache refill in progress.
REQ-012 SHALL have port snoop_hit  output  1  snoop_addr matches a buffered entry.
REQ-013 SHALL have port snoop_block  output  WORD_SIZE*BLOCK_SIZE  data of the matching entry.
REQ-014 SHALL have port mem_addr  output  ADDR_SIZE  block address driven to data memory.
REQ-015 SHALL have port mem_block  output  WORD_SIZE*BLOCK_SIZE  block data driven to data memory.
REQ-016 SHALL have port mem_write_enable  output  1  memory write strobe.
REQ-017 SHALL have port mem_ack  input  1  memory has committed the current write.
REQ-018 SHALL have port empty  output  1  no entries held.

Function
REQ-019 SHALL be a FIFO of DEPTH {addr, block} entries with wrapping head/tail pointers and a count of width log2(DEPTH)+1.
REQ-020 SHALL drive evict_ready = (count < DEPTH) from registered state only; a push occurs on an edge where evict_valid and evict_ready are both 1.
REQ-021 SHALL NOT accept a push while full, even if a pop occurs on the same edge.
REQ-022 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-023 SHALL allow duplicate addresses; each push is a separate entry.
REQ-024 SHALL compute snoop_hit/snoop_block combinationally over all valid entries; youngest match wins; snoop_block is 0 when snoop_hit is 0.
REQ-025 SHALL treat an entry being popped on the current edge as still valid for snoop in that cycle.
REQ-026 SHALL run drain FSM IDLE -> WRITE when count > 0; WRITE -> WAIT_ACK unconditionally after one cycle; WAIT_ACK -> IDLE on mem_ack, popping the head on that edge.
REQ-027 SHALL assert mem_write_enable only in WRITE, exactly one cycle per entry, with mem_addr/mem_block equal to the head entry.
REQ-028 SHALL hold mem_addr/mem_block stable from WRITE through the ack edge; mem_ack is ignored outside WAIT_ACK.
REQ-029 SHALL produce first mem_write_enable in the cycle following the edge after a push into an empty buffer (push edge N, IDLE->WRITE at N+1).
REQ-030 SHALL drain entries strictly in push order; mem_ack held high continuously yields one entry per 3 cycles.

Reset
REQ-031 SHALL on rst_n low immediately clear count, pointers, and state to IDLE, discarding buffered entries, including mid-write.
REQ-032 SHALL hold in reset: evict_ready=1, empty=1, snoop_hit=0, snoop_block=0, mem_write_enable=0, mem_addr=0, mem_block=0.

Structure
REQ-033 SHALL take WORD_SIZE, BLOCK_SIZE, ADDR_SIZE and FSM state encodings from the shared parameters include.
REQ-034 SHALL be a single module; the snoop priority match may be a sub-module named wb_snoop_match.

Verification
REQ-035 SHALL test single push addr 0x0000123 with mem_ack 2 cycles after the strobe -> one mem_write_enable pulse with mem_addr 0x0000123, empty=1 after ack.
REQ-036 SHALL test 4 pushes with mem_ack held 0 -> evict_ready=0 after the 4th, 5th evict_valid not accepted, then 4 writes in order.
REQ-037 SHALL test pushes of 0x10 (data A) then 0x10 (data B), snoop 0x10 -> snoop_hit=1 with data B; snoop 0x11 -> snoop_hit=0, snoop_block=0.
REQ-038 SHALL test full buffer with push and ack on the same edge -> push rejected, count drops to 3, evict_ready=1 next cycle.
REQ-039 SHALL test rst_n low during WAIT_ACK with 3 entries -> mem_write_enable=0, empty=1 immediately, no further writes after release.

Source files
------------

// File: rtl/wb_buffer_pkg.sv
// Shared parameters and drain FSM state encoding for the write-back buffer.
package wb_buffer_pkg;

  localparam int unsigned WB_WORD_SIZE  = 32;
  localparam int unsigned WB_BLOCK_SIZE = 16;
  localparam int unsigned WB_ADDR_SIZE  = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_snoop_match.sv
// Youngest-wins address match across the valid window of the write-back FIFO.
module wb_snoop_match
  import wb_buffer_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = WB_ADDR_SIZE,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic [ADDR_SIZE-1:0] addr_table [DEPTH],
  input  logic [PTR_W-1:0]     head,
  input  logic [CNT_W-1:0]     count,
  input  logic [ADDR_SIZE-1:0] snoop_addr,
  output logic                 hit,
  output logic [PTR_W-1:0]     hit_idx
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addr_table[idx] == snoop_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: FIFO of evicted dirty blocks drained to memory one at a time,
// with a combinational snoop port so refills see data not yet written back.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WB_WORD_SIZE,
  parameter int unsigned BLOCK_SIZE = WB_BLOCK_SIZE,
  parameter int unsigned ADDR_SIZE  = WB_ADDR_SIZE,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             evict_valid,
  input  logic [ADDR_SIZE-1:0]             evict_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  evict_block,
  output logic                             evict_ready,
  input  logic [ADDR_SIZE-1:0]             snoop_addr,
  output logic                             snoop_hit,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]  snoop_block,
  output logic [ADDR_SIZE-1:0]             mem_addr,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]  mem_block,
  output logic                             mem_write_enable,
  input  logic                             mem_ack,
  output logic                             empty
);

  localparam int unsigned BLK_W = WORD_SIZE * BLOCK_SIZE;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
  logic [BLK_W-1:0]     data_mem [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  wb_state_e        state_q, state_d;

  logic             push, pop;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;

  assign evict_ready = (count_q < CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign push        = evict_valid && evict_ready;
  assign pop         = (state_q == ST_WAIT_ACK) && mem_ack;

  // Storage needs no reset: validity is carried entirely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= evict_addr;
      data_mem[tail_q] <= evict_block;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (count_q != '0) state_d = ST_WRITE;
      ST_WRITE:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (mem_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Head entry is presented from WRITE through the ack edge; zero while idle.
  always_comb begin
    mem_write_enable = (state_q == ST_WRITE);
    mem_addr         = '0;
    mem_block        = '0;
    if (state_q != ST_IDLE) begin
      mem_addr  = addr_mem[head_q];
      mem_block = data_mem[head_q];
    end
  end

  wb_snoop_match #(
    .ADDR_SIZE (ADDR_SIZE),
    .DEPTH     (DEPTH)
  ) u_snoop_match (
    .addr_table (addr_mem),
    .head       (head_q),
    .count      (count_q),
    .snoop_addr (snoop_addr),
    .hit        (match_hit),
    .hit_idx    (match_idx)
  );

  assign snoop_hit   = match_hit;
  assign snoop_block = match_hit ? data_mem[match_idx] : '0;

endmodule

// File: tb/tb_wb_buffer.sv
// Directed self-checking bench for wb_buffer: snoop vector table plus drain/reset sequences.
module tb_wb_buffer;

  localparam int unsigned AW = 28;
  localparam int unsigned BW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          evict_valid;
  logic [AW-1:0] evict_addr;
  logic [BW-1:0] evict_block;
  logic          evict_ready;
  logic [AW-1:0] snoop_addr;
  logic          snoop_hit;
  logic [BW-1:0] snoop_block;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_block;
  logic          mem_write_enable;
  logic          mem_ack;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wa_q [$];
  logic [BW-1:0] wb_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic          hit;
    logic [BW-1:0] blk;
  } snoop_vec_t;

  snoop_vec_t vt [5];

  always #5 clk = ~clk;

  wb_buffer #(
    .WORD_SIZE  (32),
    .BLOCK_SIZE (16),
    .ADDR_SIZE  (28),
    .DEPTH      (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .evict_valid      (evict_valid),
    .evict_addr       (evict_addr),
    .evict_block      (evict_block),
    .evict_ready      (evict_ready),
    .snoop_addr       (snoop_addr),
    .snoop_hit        (snoop_hit),
    .snoop_block      (snoop_block),
    .mem_addr         (mem_addr),
    .mem_block        (mem_block),
    .mem_write_enable (mem_write_enable),
    .mem_ack          (mem_ack),
    .empty            (empty)
  );

  // Log every write strobe cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_write_enable === 1'b1) begin
      wa_q.push_back(mem_addr);
      wb_q.push_back(mem_block);
    end
  end

  function automatic logic [BW-1:0] mk_blk(input logic [31:0] w);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[BW-1-32*i -: 32] = w + 32'(i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [BW-1:0] b);
    evict_addr  = a;
    evict_block = b;
    evict_valid = 1'b1;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic do_reset();
    evict_valid = 1'b0;
    mem_ack     = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wa_q.delete();
    wb_q.delete();
  endtask

  task automatic drain(output int n);
    n       = 0;
    mem_ack = 1'b1;
    while (empty !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    logic [BW-1:0] blk_h, blk_a, blk_b, d1;

    blk_h = mk_blk(32'h3000_0000);
    blk_a = mk_blk(32'h1A00_0000);
    blk_b = mk_blk(32'h1B00_0000);
    d1    = mk_blk(32'hD100_0000);

    vt[0] = '{addr: 28'h0000030, hit: 1'b1, blk: blk_h};
    vt[1] = '{addr: 28'h0000010, hit: 1'b1, blk: blk_b};
    vt[2] = '{addr: 28'h0000011, hit: 1'b0, blk: '0};
    vt[3] = '{addr: 28'h0001003, hit: 1'b0, blk: '0};
    vt[4] = '{addr: 28'h0001000, hit: 1'b0, blk: '0};

    rst_n       = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_block = '0;
    snoop_addr  = 28'h0000123;
    mem_ack     = 1'b0;

    // Reset state
    #3;
    chk("rst_evict_ready", evict_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_snoop_hit", snoop_hit, 0);
    chk("rst_snoop_block", snoop_block, 0);
    chk("rst_mwe", mem_write_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_block", mem_block, 0);
    do_reset();

    // Single push, strobe latency, held outputs, late ack
    push_one(28'h0000123, d1);
    chk("s_mwe_push", mem_write_enable, 0);
    chk("s_empty_push", empty, 0);
    tick();
    chk("s_mwe_write", mem_write_enable, 1);
    chk("s_addr_write", mem_addr, 28'h0000123);
    chk("s_block_write", mem_block, d1);
    tick();
    chk("s_mwe_wait", mem_write_enable, 0);
    chk("s_addr_wait", mem_addr, 28'h0000123);
    tick();
    chk("s_block_wait2", mem_block, d1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("s_empty_ack", empty, 1);
    tick();
    tick();
    chk("s_nwrites", wa_q.size(), 1);
    if (wa_q.size() > 0) chk("s_wr_addr", wa_q[0], 28'h0000123);

    // Fill to full, reject fifth, drain in order at one per 3 cycles
    do_reset();
    for (int i = 0; i < 4; i++) push_one(28'h0001000 + 28'(i), mk_blk(32'hA000_0000 + 32'(i * 256)));
    chk("f_ready_full", evict_ready, 0);
    push_one(28'h0001FFF, mk_blk(32'hDEAD_0000));
    chk("f_ready_after5", evict_ready, 0);
    drain(n);
    chk("f_drain_cycles", n, 10);
    chk("f_empty", empty, 1);
    chk("f_nwrites", wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_q.size()) begin
        chk("f_wr_addr", wa_q[i], 28'h0001000 + 28'(i));
        chk("f_wr_block", wb_q[i], mk_blk(32'hA000_0000 + 32'(i * 256)));
      end
    end

    // Snoop table: duplicates, youngest wins, misses, stale slots ignored
    do_reset();
    push_one(28'h0000030, blk_h);
    push_one(28'h0000010, blk_a);
    push_one(28'h0000010, blk_b);
    for (int i = 0; i < 5; i++) begin
      snoop_addr = vt[i].addr;
      #1;
      chk("snp_hit", snoop_hit, vt[i].hit);
      chk("snp_block", snoop_block, vt[i].blk);
    end
    // Head entry stays visible during its pop cycle
    snoop_addr = 28'h0000030;
    mem_ack    = 1'b1;
    #1;
    chk("snp_pop_hit", snoop_hit, 1);
    chk("snp_pop_block", snoop_block, blk_h);
    tick();
    mem_ack = 1'b0;
    chk("snp_after_pop_hit", snoop_hit, 0);
    chk("snp_after_pop_block", snoop_block, 0);
    drain(n);
    chk("snp_empty", empty, 1);
    chk("snp_nwrites", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      chk("snp_wr0", wa_q[0], 28'h0000030);
      chk("snp_wr1_block", wb_q[1], blk_a);
      chk("snp_wr2_block", wb_q[2], blk_b);
    end

    // Full buffer: push and ack on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) push_one(28'h0002000 + 28'(i), mk_blk(32'hC000_0000 + 32'(i)));
    chk("fp_ready_full", evict_ready, 0);
    evict_addr  = 28'h0002077;
    evict_block = mk_blk(32'h7777_0000);
    evict_valid = 1'b1;
    mem_ack     = 1'b1;
    tick();
    evict_valid = 1'b0;
    mem_ack     = 1'b0;
    chk("fp_ready_after", evict_ready, 1);
    chk("fp_empty_after", empty, 0);
    snoop_addr = 28'h0002077;
    #1;
    chk("fp_rejected_snoop", snoop_hit, 0);
    drain(n);
    chk("fp_drain_cycles", n, 9);
    chk("fp_nwrites", wa_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wa_q.size()) chk("fp_wr_addr", wa_q[i], 28'h0002000 + 28'(i));

    // Reset asserted while waiting for ack with 3 entries
    do_reset();
    for (int i = 0; i < 3; i++) push_one(28'h0003000 + 28'(i), mk_blk(32'hE000_0000 + 32'(i)));
    chk("r_in_wait_mwe", mem_write_enable, 0);
    chk("r_one_write", wa_q.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("r_mwe", mem_write_enable, 0);
    chk("r_empty", empty, 1);
    chk("r_ready", evict_ready, 1);
    chk("r_mem_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    wa_q.delete();
    wb_q.delete();
    mem_ack = 1'b1;
    repeat (12) tick();
    mem_ack = 1'b0;
    chk("r_no_writes", wa_q.size(), 0);
    chk("r_empty_after", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
